// File: rtl/sr_framer_pkg.sv
// Shared types and constants for the shift-register word framer.
// The optional statistics counters are enabled with SR_FRAMER_STATS_EN.
package sr_framer_pkg;

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   localparam logic [15:0] SYNC_DEFAULT = 16'hA5C3;
   localparam int          CNT_W        = 16;

   // Saturating increment used by the statistics counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sr_word_framer_if.sv
// Bus between the framer and its surroundings: shift-register taps, word handshake, status.
// word_cnt/drop_cnt exist only when SR_FRAMER_STATS_EN is defined.
interface sr_word_framer_if #(
   parameter int MSB = 16
);
   import sr_framer_pkg::*;

   logic           sr_en;
   logic           sr_dir;
   logic [MSB-1:0] sr_out;
   logic [MSB-1:0] word;
   logic           word_valid;
   logic           word_ready;
   logic           locked;
   logic           overflow;
   logic           ovf_clr;
`ifdef SR_FRAMER_STATS_EN
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] drop_cnt;
`endif

   modport master (
      input  sr_en, sr_dir, sr_out, word_ready, ovf_clr,
`ifdef SR_FRAMER_STATS_EN
      output word_cnt, drop_cnt,
`endif
      output word, word_valid, locked, overflow
   );

   modport slave (
      output sr_en, sr_dir, sr_out, word_ready, ovf_clr,
`ifdef SR_FRAMER_STATS_EN
      input  word_cnt, drop_cnt,
`endif
      input  word, word_valid, locked, overflow
   );

endinterface

// File: rtl/sr_word_hold.sv
// One-entry hold register for framed words: valid/ready handshake, drop detection, sticky overflow.
// Handshake and drop counters are present only when SR_FRAMER_STATS_EN is defined.
module sr_word_hold
   import sr_framer_pkg::*;
#(
   parameter int MSB = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             capture,
   input  logic [MSB-1:0]   data,
   input  logic             word_ready,
   input  logic             ovf_clr,
`ifdef SR_FRAMER_STATS_EN
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] drop_cnt,
`endif
   output logic [MSB-1:0]   word,
   output logic             word_valid,
   output logic             overflow
);

   logic accept;
   logic load;
   logic drop;

   // A capture may reuse the slot on the same edge the old word is accepted.
   assign accept = word_valid && word_ready;
   assign load   = capture && (!word_valid || word_ready);
   assign drop   = capture && word_valid && !word_ready;

   // NOTE: all state below updates with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word       <= '0;
         word_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (load) begin
            word       <= data;
            word_valid <= 1'b1;
         end else if (accept) begin
            word_valid <= 1'b0;
         end

         // A drop in the same cycle as a clear keeps the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef SR_FRAMER_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (accept) word_cnt <= sat_inc(word_cnt);
         if (drop)   drop_cnt <= sat_inc(drop_cnt);
      end
   end
`endif

endmodule

// File: rtl/sr_word_framer.sv
// Locks onto SYNC in the shifted stream, then frames every MSB further shifts into a word.
// Build with SR_FRAMER_STATS_EN for saturating handshake/drop counters on the bus.
module sr_word_framer
   import sr_framer_pkg::*;
#(
   parameter int             MSB  = 16,
   parameter logic [MSB-1:0] SYNC = MSB'(SYNC_DEFAULT)
) (
   input logic            clk,
   input logic            rstn,
   sr_word_framer_if.master bus
);

   localparam int                CNT_BW = (MSB > 1) ? $clog2(MSB) : 1;
   localparam logic [CNT_BW-1:0] LAST   = CNT_BW'(MSB - 1);

   state_t            state;
   logic [CNT_BW-1:0] bit_cnt;
   logic              en_q;
   logic              dir_q;
   logic              dir_flip;
   logic              capture;

   // en_q marks the cycle in which sr_out holds the value produced by the previous shift.
   assign dir_flip = bus.sr_en && (bus.sr_dir != dir_q);
   assign capture  = (state == COLLECT) && en_q && (bit_cnt == LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= HUNT;
         bus.locked <= 1'b0;
         bit_cnt    <= '0;
         en_q       <= 1'b0;
         dir_q      <= 1'b0;
      end else begin
         en_q <= bus.sr_en;
         if (bus.sr_en) dir_q <= bus.sr_dir;

         case (state)
            HUNT: begin
               if (en_q && (bus.sr_out == SYNC)) begin
                  state      <= COLLECT;
                  bus.locked <= 1'b1;
                  bit_cnt    <= '0;
               end
            end
            COLLECT: begin
               // A completed word is still captured; only the partial count is abandoned.
               if (dir_flip) begin
                  state      <= HUNT;
                  bus.locked <= 1'b0;
                  bit_cnt    <= '0;
               end else if (en_q) begin
                  bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   sr_word_hold #(
      .MSB (MSB)
   ) u_hold (
      .clk        (clk),
      .rstn       (rstn),
      .capture    (capture),
      .data       (bus.sr_out),
      .word_ready (bus.word_ready),
      .ovf_clr    (bus.ovf_clr),
`ifdef SR_FRAMER_STATS_EN
      .word_cnt   (bus.word_cnt),
      .drop_cnt   (bus.drop_cnt),
`endif
      .word       (bus.word),
      .word_valid (bus.word_valid),
      .overflow   (bus.overflow)
   );

endmodule

// File: tb/tb_sr_word_framer.sv
// Bench for sr_word_framer: directed scenarios plus random traffic against a shift-count model.
// Counter outputs are also checked when SR_FRAMER_STATS_EN is defined.
module tb_sr_word_framer;
   import sr_framer_pkg::*;

   localparam int          MSB  = 16;
   localparam logic [15:0] SYNC = 16'hA5C3;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   sr_word_framer_if #(.MSB(MSB)) bus ();

   sr_word_framer #(.MSB(MSB), .SYNC(SYNC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // External shift register and the behavioural expectation of the framer.
   logic [15:0] sr;
   bit          m_locked;
   int          m_shifts;
   bit          m_en_q;
   bit          m_dir;
   bit          m_valid;
   logic [15:0] m_word;
   bit          m_ovf;
   int          m_words;
   int          m_drops;
   bit          cur_dir;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_shifts = 0; m_en_q = 0; m_dir = 0;
      m_valid = 0; m_word = '0; m_ovf = 0; m_words = 0; m_drops = 0;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".word"},       32'(bus.word),       32'(m_word));
      check({tag, ".word_valid"}, 32'(bus.word_valid), 32'(m_valid));
      check({tag, ".locked"},     32'(bus.locked),     32'(m_locked));
      check({tag, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
`ifdef SR_FRAMER_STATS_EN
      check({tag, ".word_cnt"},   32'(bus.word_cnt),   32'(m_words));
      check({tag, ".drop_cnt"},   32'(bus.drop_cnt),   32'(m_drops));
`endif
   endtask

   // One clock: apply inputs, predict the post-edge state from the framing rules, shift, compare.
   task automatic step(input bit en, input bit dir, input bit sin, input bit ready, input bit clr);
      bit          nxt_locked;
      int          nxt_shifts;
      bit          capture;
      bit          drop;
      logic [15:0] cap_val;
      bus.sr_en      = en;
      bus.sr_dir     = dir;
      bus.word_ready = ready;
      bus.ovf_clr    = clr;

      nxt_locked = m_locked;
      nxt_shifts = m_shifts;
      capture    = 0;
      cap_val    = sr;
      if (m_en_q && !m_locked && sr == SYNC) begin
         nxt_locked = 1;
         nxt_shifts = 0;
      end else if (m_en_q && m_locked) begin
         nxt_shifts = m_shifts + 1;
         if (nxt_shifts == MSB) begin
            capture    = 1;
            nxt_shifts = 0;
         end
      end
      if (m_locked && en && dir != m_dir) begin
         nxt_locked = 0;
         nxt_shifts = 0;
      end

      drop = capture && m_valid && !ready;
      if (m_valid && ready && m_words < 65535) m_words++;
      if (drop && m_drops < 65535) m_drops++;
      if (capture && !drop) begin
         m_word  = cap_val;
         m_valid = 1;
      end else if (m_valid && ready) begin
         m_valid = 0;
      end
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_en_q   = en;
      if (en) m_dir = dir;
      m_locked = nxt_locked;
      m_shifts = nxt_shifts;

      @(posedge clk);
      #1;
      if (en) sr = dir ? {sr[14:0], sin} : {sin, sr[15:1]};
      bus.sr_out = sr;
      compare_all("step");
   endtask

   // Feeds word bits so that v sits in the register after the last of the 16 shifts.
   task automatic shift_range(input logic [15:0] v, input int lo, input int hi,
                              input bit dir, input bit ready);
      for (int i = lo; i <= hi; i++) begin
         step(1'b1, dir, dir ? v[15-i] : v[i], ready, 1'b0);
      end
   endtask

   task automatic shift_word(input logic [15:0] v, input bit dir, input bit ready);
      shift_range(v, 0, 15, dir, ready);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] cand;
      logic [15:0] beef;
      bit          b;

      rstn = 1'b0;
      bus.sr_en = 0; bus.sr_dir = 0; bus.word_ready = 0; bus.ovf_clr = 0;
      sr = '0; bus.sr_out = sr;
      cur_dir = 1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all("reset");
      rstn = 1'b1;

      // No sync in 40 shifts: 24 random bits avoiding SYNC, then 16 zeros.
      for (int i = 0; i < 40; i++) begin
         b    = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
         cand = {sr[14:0], b};
         if (cand == SYNC) b = ~b;
         step(1'b1, 1'b1, b, 1'b1, 1'b0);
      end
      check("hunt.locked", 32'(bus.locked), 32'd0);
      check("hunt.valid",  32'(bus.word_valid), 32'd0);

      // Lock, first word, continuous framing.
      shift_word(SYNC, 1'b1, 1'b1);
      check("sync.not_yet_locked", 32'(bus.locked), 32'd0);
      shift_range(16'h1234, 0, 0, 1'b1, 1'b1);
      check("sync.locked", 32'(bus.locked), 32'd1);
      shift_range(16'h1234, 1, 15, 1'b1, 1'b1);
      beef = 16'hBEEF;
      step(1'b1, 1'b1, beef[15], 1'b1, 1'b0);
      check("first.valid", 32'(bus.word_valid), 32'd1);
      check("first.word",  32'(bus.word), 32'h1234);
      shift_range(beef, 1, 15, 1'b1, 1'b1);
      check("first.pulse", 32'(bus.word_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("second.word", 32'(bus.word), 32'hBEEF);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

      // Back-pressure: second word dropped, overflow set, then cleared.
      shift_word(16'h1111, 1'b1, 1'b0);
      shift_word(16'h2222, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("ovf.word", 32'(bus.word), 32'h1111);
      check("ovf.flag", 32'(bus.overflow), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("ovf.clr", 32'(bus.overflow), 32'd0);

      // Capture on the same edge as an accept.
      shift_word(16'h3333, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("simul.word",  32'(bus.word), 32'h3333);
      check("simul.valid", 32'(bus.word_valid), 32'd1);
      check("simul.ovf",   32'(bus.overflow), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

      // Direction flip mid-word, then re-sync in the other direction.
      shift_range(16'h4444, 0, 6, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("flip.locked", 32'(bus.locked), 32'd0);
      shift_word(16'h0000, 1'b0, 1'b1);
      check("flip.no_word", 32'(bus.word_valid), 32'd0);
      shift_word(SYNC, 1'b0, 1'b1);
      shift_word(16'h5A5A, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("resync.word",  32'(bus.word), 32'h5A5A);
      check("resync.valid", 32'(bus.word_valid), 32'd1);
      cur_dir = 0;

      // Random traffic with occasional sync injection and rare direction flips.
      for (int i = 0; i < 600; i++) begin
         if (i % 70 == 5) begin
            shift_word(SYNC, cur_dir, 1'($urandom_range(0, 1)));
         end else begin
            if ($urandom_range(0, 39) == 0) cur_dir = ~cur_dir;
            step($urandom_range(0, 3) != 0, cur_dir, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
         end
      end

      // Asynchronous reset mid-word with a word pending.
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      shift_word(16'h0000, 1'b1, 1'b0);
      shift_word(SYNC, 1'b1, 1'b0);
      shift_word(16'h6789, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("pre_rst.valid", 32'(bus.word_valid), 32'd1);
      shift_range(16'hABCD, 0, 4, 1'b1, 1'b0);
      #2 rstn = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      compare_all("post_rst");
      shift_word(16'h0000, 1'b1, 1'b1);
      shift_word(SYNC, 1'b1, 1'b1);
      shift_word(16'h0F0F, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("recover.word", 32'(bus.word), 32'h0F0F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
